gmii_tx_arbiter: RTL and testbench
==================================

# gmii_tx_arbiter

Two-source transmit scheduler that shares the single GMII transmit path between two byte-stream frame sources, e.g. the UDP and ARP frame builders. It arbitrates round-robin at frame boundaries and inserts the preamble and SFD. It enforces the minimum inter-frame gap and flags source underrun on gmii_tx_err. Its GMII outputs drive the GMII-to-RGMII DDR output stage directly, in the same gmii_clk domain.

## Interface
- PREAMBLE_LEN, default 7: number of 0x55 bytes before the SFD; must be ≥1.
- IFG_CYCLES, default 12: minimum number of gmii_tx_en-low cycles between frames; must be ≥1.
- gmii_clk  in  1  125 MHz transmit clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- s0_data  in  8  source 0 payload byte.
- s0_valid  in  1  source 0 byte valid.
- s0_last  in  1  marks the final byte of the source 0 frame.
- s0_ready  out  1  source 0 byte accepted when s0_valid && s0_ready at a rising edge.
- s1_data, s1_valid, s1_last, s1_ready: same as the s0 ports, for source 1.
- gmii_tx_en  out  1  registered GMII transmit enable.
- gmii_tx_err  out  1  registered GMII transmit error.
- gmii_tx_data  out  8  registered GMII transmit byte.
- busy  out  1  high whenever the state is not IDLE.
- grant  out  1  index of the source that owns the current frame; meaningful only while busy.

## Operation
- States: IDLE, PRE, SFD, DATA, IFG. Reset state is IDLE.
- IDLE
  - If either s*_valid is high, select a winner, latch grant, and go to PRE.
  - If only one source requests, it wins.
  - If both request, the source ≠ last_grant wins.
  - last_grant resets to 1, so s0 wins the first tie.
- PRE: outputs PREAMBLE_LEN bytes of 0x55 with tx_en=1, then goes to SFD.
- SFD: outputs 0xD5 with tx_en=1, then goes to DATA.
- DATA
  - s{grant}_ready is high, combinationally.
  - An accepted byte is driven on gmii_tx_data in the next cycle with tx_en=1 and err=0.
  - When a byte with last=1 is accepted, go to IFG and update last_grant.
- Underrun: in a ready cycle where valid=0, the next cycle outputs tx_en=1, err=1, data=0x00. The state stays DATA until last is accepted. The frame is corrupted, not aborted.
- IFG
  - tx_en, err and data are 0.
  - Counts IFG_CYCLES cycles, then returns to IDLE.
  - Requests arriving during IFG are held by the source and sampled in IDLE.
- The non-granted source's ready is always 0. Its valid is ignored until IDLE.
- Source data is not inspected; no CRC or padding is added. FCS is appended upstream.

## Timing
- Reset values: gmii_tx_en=0, gmii_tx_err=0, gmii_tx_data=0x00, busy=0, grant=0, last_grant=1. s0_ready and s1_ready are 0 while rst is high.
- Reset mid-frame: outputs are 0 from the cycle after rst is sampled high. The next state is IDLE, with no IFG enforced after a reset.
- Request sampled in IDLE in cycle N:
  - 0x55 in cycles N+1..N+PREAMBLE_LEN.
  - 0xD5 in cycle N+PREAMBLE_LEN+1.
  - s{grant}_ready is high from cycle N+PREAMBLE_LEN+1.
  - The first payload byte is output in cycle N+PREAMBLE_LEN+2 if valid was high in the previous cycle.
- Latency from source acceptance to GMII output is exactly 1 cycle.
- Last byte accepted at the edge ending cycle M:
  - The last byte is output in cycle M+1.
  - tx_en is low in cycles M+2..M+1+IFG_CYCLES.
  - ready drops in cycle M+1.
- Earliest next IDLE sample is cycle M+1+IFG_CYCLES. The earliest next preamble byte is in cycle M+2+IFG_CYCLES, giving exactly IFG_CYCLES idle cycles.
- grant and busy are registered and change on the edge that leaves IDLE or enters IDLE.
- Simultaneous last and new request: cannot preempt; the new request waits for IFG.

## Test plan
- **Single frame:** s0 frame 0x11,0x22,0x33,0x44, valid first sampled in cycle N, default parameters.
  - 0x55 in N+1..N+7, 0xD5 in N+8, payload in N+9..N+12.
  - tx_en=0 from N+13; s1_ready=0 throughout.
- **Tie after reset:** s0 and s1 both valid in the same IDLE cycle.
  - s0 frame is sent first.
  - s1 preamble starts exactly 12 cycles after s0 tx_en falls.
  - A third back-to-back tie goes to s0 again (round-robin alternation).
- **Back-to-back single source:** s0 holds valid continuously for three 64-byte frames.
  - Each frame is 8+64 tx_en cycles.
  - Each gap is exactly 12 cycles.
- **Underrun:** s0 deasserts valid for 2 ready cycles after byte 3.
  - Two output cycles with tx_en=1, err=1, data=0x00.
  - Byte 4 follows immediately, err returns to 0, and the frame completes normally.
- **Reset mid-DATA:** rst pulsed high for 1 cycle during byte 10.
  - tx_en=0 and readys=0 in the next cycle.
  - A subsequent tie is granted to s0, and the preamble appears 1 cycle after the request is sampled.
- **Parameter override:** PREAMBLE_LEN=3, IFG_CYCLES=4.
  - 3×0x55 then 0xD5.
  - Inter-frame gap is exactly 4 cycles.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
// Shares one GMII transmit path between two byte-stream frame sources.
// A frame is granted round-robin when the path is idle. The arbiter emits the
// preamble and SFD, then forwards the granted source's bytes with one cycle of
// latency. It then holds tx_en low for the inter-frame gap before the next grant.
// A byte missing during the payload phase is sent as an error byte (0x00 with
// tx_err=1). The frame carries on until the source delivers its last byte.
//
// Ports
//   gmii_clk            125 MHz transmit clock (only clock)
//   rst                 synchronous reset, active-high
//   s0_data/valid/last  source 0 byte stream
//   s0_ready            source 0 byte accepted on valid && ready
//   s1_*                same for source 1
//   gmii_tx_en/err/data registered GMII transmit outputs
//   busy                high whenever the scheduler is not idle
//   grant               owner of the current frame (meaningful while busy)
module gmii_tx_arbiter #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       gmii_clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       gmii_tx_en,
  output logic       gmii_tx_err,
  output logic [7:0] gmii_tx_data,
  output logic       busy,
  output logic       grant
);

  // One shared counter serves both the preamble and the inter-frame gap.
  localparam int CNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The IDLE cycle already loads the first 0x55. The PRE state therefore covers
  // only the remaining PREAMBLE_LEN-1 bytes, and is skipped when PREAMBLE_LEN is 1.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PREAMBLE_LEN > 1) ? PREAMBLE_LEN - 2 : 0);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [7:0]       PRE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_IFG
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_err_q, tx_err_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             data_phase;

  // Round-robin pick: a lone requester wins; on a tie the source that did not
  // send the previous frame wins.
  function automatic logic pick_winner(input logic v0, input logic v1, input logic lg);
    if (v0 && v1) begin
      return ~lg;
    end
    return v1;
  endfunction

  assign g_valid = grant_q ? s1_valid : s0_valid;
  assign g_last  = grant_q ? s1_last  : s0_last;
  assign g_data  = grant_q ? s1_data  : s0_data;

  // Ready is combinational from state so the source sees it in the same cycle
  // that the SFD is on the wire.
  assign data_phase = (state_q == ST_DATA) && !rst;
  assign s0_ready   = data_phase && !grant_q;
  assign s1_ready   = data_phase &&  grant_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_en_d      = 1'b0;
    tx_err_d     = 1'b0;
    tx_data_d    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d   = pick_winner(s0_valid, s1_valid, last_grant_q);
          state_d   = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
          cnt_d     = '0;
          tx_en_d   = 1'b1;
          tx_data_d = PRE_BYTE;
        end
      end
      ST_PRE: begin
        tx_en_d   = 1'b1;
        tx_data_d = PRE_BYTE;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SFD: begin
        tx_en_d   = 1'b1;
        tx_data_d = SFD_BYTE;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (g_valid) begin
          tx_data_d = g_data;
          if (g_last) begin
            state_d      = ST_IFG;
            cnt_d        = '0;
            last_grant_d = grant_q;
          end
        end else begin
          // Underrun: keep the frame going but mark this byte as corrupt.
          tx_err_d = 1'b1;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tx_en_q      <= 1'b0;
      tx_err_q     <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_en_q      <= tx_en_d;
      tx_err_q     <= tx_err_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_err  = tx_err_q;
  assign gmii_tx_data = tx_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign grant        = grant_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Testbench for gmii_tx_arbiter: drives two frame sources on a default
// instance, and a single source on an instance with a short preamble and gap.
// The driver logs every byte the DUT accepts, and every underrun slot, into a
// per-source expectation queue. Separate monitors rebuild each expected output
// cycle from frame-level rules: preamble/SFD, round-robin choice, gap length,
// reset behaviour. They pop the payload from those queues.
module tb_gmii_tx_arbiter;
  localparam int P  = 7;
  localparam int G  = 12;
  localparam int P2 = 3;
  localparam int G2 = 4;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic [7:0] dd [3];
  logic       vv [3];
  logic       ll [3];
  logic       r0, r1, tx_en, tx_err, busy, grant;
  logic [7:0] tx_data;
  logic       d2_r0, d2_r1, d2_en, d2_err, d2_busy, d2_grant;
  logic [7:0] d2_data;

  gmii_tx_arbiter u_dut (
    .gmii_clk(clk), .rst(rst),
    .s0_data(dd[0]), .s0_valid(vv[0]), .s0_last(ll[0]), .s0_ready(r0),
    .s1_data(dd[1]), .s1_valid(vv[1]), .s1_last(ll[1]), .s1_ready(r1),
    .gmii_tx_en(tx_en), .gmii_tx_err(tx_err), .gmii_tx_data(tx_data),
    .busy(busy), .grant(grant)
  );

  gmii_tx_arbiter #(.PREAMBLE_LEN(P2), .IFG_CYCLES(G2)) u_dut2 (
    .gmii_clk(clk), .rst(rst),
    .s0_data(dd[2]), .s0_valid(vv[2]), .s0_last(ll[2]), .s0_ready(d2_r0),
    .s1_data(8'h00), .s1_valid(1'b0), .s1_last(1'b0), .s1_ready(d2_r1),
    .gmii_tx_en(d2_en), .gmii_tx_err(d2_err), .gmii_tx_data(d2_data),
    .busy(d2_busy), .grant(d2_grant)
  );

  typedef struct {
    int len;
    int pat;
    int seed;
    int stall_after;
    int stall_n;
    int pre_idle;
  } frame_t;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       l;
  } exp_t;

  frame_t fq   [3][$];
  exp_t   expq [3][$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] fbyte(input frame_t f, input int i);
    if (f.pat != 0) return 8'((i + 1) * 17);
    return 8'(f.seed + i * 29 + i * i * 3);
  endfunction

  function automatic frame_t mkf(input int len, input int pat, input int sa,
                                 input int sn, input int pi);
    frame_t f;
    f.len         = len;
    f.pat         = pat;
    f.seed        = int'($urandom_range(255, 0));
    f.stall_after = sa;
    f.stall_n     = sn;
    f.pre_idle    = pi;
    return f;
  endfunction

  // Driver state (owned by the main process only).
  frame_t cur [3];
  logic   act [3];
  int     idx [3];
  int     stl [3];
  int     pre [3];
  logic   rst_req;

  task automatic step();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      logic rd;
      exp_t e;
      rd = (s == 0) ? r0 : ((s == 1) ? r1 : d2_r0);
      if (act[s] && rd) begin
        if (vv[s]) begin
          e.d = dd[s]; e.e = 1'b0; e.l = ll[s];
          expq[s].push_back(e);
          if (ll[s]) act[s] = 1'b0;
          else idx[s]++;
        end else begin
          e.d = 8'h00; e.e = 1'b1; e.l = 1'b0;
          expq[s].push_back(e);
          if (stl[s] > 0) stl[s]--;
        end
      end
    end
    @(posedge clk);
    #1;
    rst     = rst_req;
    rst_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (rst) begin
        act[s] = 1'b0;
        fq[s].delete();
      end
      if (!act[s] && fq[s].size() > 0) begin
        cur[s] = fq[s].pop_front();
        act[s] = 1'b1;
        idx[s] = 0;
        stl[s] = cur[s].stall_n;
        pre[s] = cur[s].pre_idle;
      end
      vv[s] = 1'b0;
      ll[s] = 1'b0;
      dd[s] = 8'h00;
      if (act[s]) begin
        if (pre[s] > 0) begin
          pre[s]--;
        end else if (!(idx[s] == cur[s].stall_after && stl[s] > 0)) begin
          vv[s] = 1'b1;
          dd[s] = fbyte(cur[s], idx[s]);
          ll[s] = (idx[s] == cur[s].len - 1);
        end
      end
    end
  endtask

  task automatic run(input string nm, input int budget);
    int n;
    n = 0;
    while ((act[0] || act[1] || act[2] || fq[0].size() > 0 || fq[1].size() > 0 ||
            fq[2].size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({nm, " finished within budget"}, int'(n < budget), 1);
    repeat (G + 4) step();
    chk({nm, " all expected bytes seen"},
        expq[0].size() + expq[1].size() + expq[2].size(), 0);
  endtask

  // Monitor for the default instance: frame-level model of the wire.
  logic mon_en  = 1'b0;
  logic mon2_en = 1'b0;
  logic m_in, m_acc, m_own, m_lg;
  int   m_pos, m_start, m_free;

  initial begin
    exp_t       e;
    logic [7:0] xd;
    logic       xe, xen;
    m_in = 1'b0; m_acc = 1'b0; m_own = 1'b0; m_lg = 1'b1;
    m_pos = 0; m_start = -1; m_free = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        xen = 1'b0; xe = 1'b0; xd = 8'h00;
        if (m_start == cyc) begin
          m_in = 1'b1; m_pos = 0; m_start = -1;
        end
        if (m_in) begin
          xen = 1'b1;
          if (m_pos < P) begin
            xd = 8'h55;
          end else if (m_pos == P) begin
            xd = 8'hD5;
            m_acc = 1'b1;
          end else if (expq[m_own].size() == 0) begin
            chk("payload byte available", 0, 1);
            m_in = 1'b0; m_acc = 1'b0; m_free = cyc + G;
          end else begin
            e  = expq[m_own].pop_front();
            xd = e.d;
            xe = e.e;
            if (e.l) begin
              m_in = 1'b0; m_free = cyc + G; m_lg = m_own;
            end
          end
          m_pos++;
        end
        chk("tx_en",   int'(tx_en),   int'(xen));
        chk("tx_err",  int'(tx_err),  int'(xe));
        chk("tx_data", int'(tx_data), int'(xd));
        chk("s0_ready", int'(r0), int'(m_acc && !m_own && !rst));
        chk("s1_ready", int'(r1), int'(m_acc &&  m_own && !rst));
        chk("busy", int'(busy), int'(m_in || cyc < m_free));
        if (m_in) chk("grant", int'(grant), int'(m_own));
        if (m_acc && vv[m_own] && ll[m_own]) m_acc = 1'b0;
        if (rst) begin
          m_in = 1'b0; m_acc = 1'b0; m_start = -1; m_free = cyc + 1; m_lg = 1'b1;
          expq[0].delete();
          expq[1].delete();
        end else if (!m_in && m_start < 0 && cyc >= m_free && (vv[0] || vv[1])) begin
          m_own   = (vv[0] && vv[1]) ? !m_lg : vv[1];
          m_start = cyc + 1;
        end
      end
    end
  end

  // Monitor for the short-preamble instance.
  int   d2_frames = 0;
  int   d2_gap    = 0;
  int   d2_pos    = 0;
  logic d2_prev   = 1'b0;

  initial begin
    exp_t       e;
    logic [7:0] xd;
    logic       xe;
    forever begin
      @(negedge clk);
      if (mon2_en) begin
        chk("d2 s1_ready", int'(d2_r1), 0);
        if (d2_busy) chk("d2 grant", int'(d2_grant), 0);
        if (d2_en) begin
          if (!d2_prev) begin
            if (d2_frames > 0) chk("d2 inter-frame gap", d2_gap, G2);
            d2_frames++;
            d2_pos = 0;
          end
          xe = 1'b0;
          xd = 8'h00;
          if (d2_pos < P2) xd = 8'h55;
          else if (d2_pos == P2) xd = 8'hD5;
          else if (expq[2].size() == 0) chk("d2 payload byte available", 0, 1);
          else begin
            e  = expq[2].pop_front();
            xd = e.d;
            xe = e.e;
          end
          chk("d2 tx_data", int'(d2_data), int'(xd));
          chk("d2 tx_err",  int'(d2_err),  int'(xe));
          d2_pos++;
          d2_gap = 0;
        end else begin
          chk("d2 idle tx_err",  int'(d2_err),  0);
          chk("d2 idle tx_data", int'(d2_data), 0);
          d2_gap++;
        end
        d2_prev = d2_en;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    rst_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      vv[s] = 1'b0; ll[s] = 1'b0; dd[s] = 8'h00; act[s] = 1'b0;
      idx[s] = 0; stl[s] = 0; pre[s] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en  = 1'b1;
    mon2_en = 1'b1;
    @(negedge clk);
    chk("reset tx_en",    int'(tx_en),   0);
    chk("reset tx_err",   int'(tx_err),  0);
    chk("reset tx_data",  int'(tx_data), 0);
    chk("reset busy",     int'(busy),    0);
    chk("reset grant",    int'(grant),   0);
    chk("reset s0_ready", int'(r0),      0);
    chk("reset s1_ready", int'(r1),      0);
    chk("reset d2 tx_en", int'(d2_en),   0);
    step();

    // Ties right after reset: s0, s1, s0, then s1 alone.
    fq[0].push_back(mkf(6, 0, 0, 0, 0));
    fq[0].push_back(mkf(5, 0, 0, 0, 0));
    fq[1].push_back(mkf(5, 0, 0, 0, 0));
    fq[1].push_back(mkf(4, 0, 0, 0, 0));
    run("tie round-robin", 1000);

    // Single fixed-pattern frame.
    fq[0].push_back(mkf(4, 1, 0, 0, 0));
    run("single frame", 500);

    // Three back-to-back 64-byte frames from s0.
    for (int k = 0; k < 3; k++) fq[0].push_back(mkf(64, 0, 0, 0, 0));
    run("back-to-back", 3000);

    // Underrun: two empty ready cycles after byte 3.
    fq[0].push_back(mkf(8, 1, 3, 2, 0));
    run("underrun", 500);

    // Reset during the payload, then a tie that must go to s0.
    fq[0].push_back(mkf(20, 0, 0, 0, 0));
    n = 0;
    while (!(act[0] && idx[0] == 9) && n < 300) begin
      step();
      n++;
    end
    chk("reached byte 10 before reset", int'(n < 300), 1);
    rst_req = 1'b1;
    step();
    fq[0].push_back(mkf(4, 0, 0, 0, 0));
    fq[1].push_back(mkf(4, 0, 0, 0, 0));
    run("tie after mid-frame reset", 500);

    // Randomized traffic on both sources.
    for (int k = 0; k < 20; k++) begin
      int len, sa, sn, s;
      len = int'($urandom_range(24, 1));
      s   = int'($urandom_range(1, 0));
      sa  = (len > 1) ? int'($urandom_range(len - 1, 1)) : 0;
      sn  = (len > 1) ? int'($urandom_range(3, 0)) : 0;
      fq[s].push_back(mkf(len, 0, sa, sn, int'($urandom_range(15, 0))));
    end
    run("random traffic", 6000);

    // Short preamble / short gap instance.
    fq[2].push_back(mkf(5, 1, 0, 0, 0));
    fq[2].push_back(mkf(5, 1, 0, 0, 0));
    run("short preamble instance", 500);
    chk("d2 frame count", d2_frames, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
